// File: rtl/mem_wb_latch.sv
// MEM/WB pipeline latch with data-memory wait handling, sticky halt and retire counter.
module mem_wb_latch (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        ihit,
   input  logic        dhit,
   input  logic        flush,
   input  logic        mem_valid,
   input  logic        mem_dREN,
   input  logic        mem_dWEN,
   input  logic        mem_regWr,
   input  logic [2:0]  mem_regSel,
   input  logic [4:0]  mem_regDst,
   input  logic [31:0] mem_nPC,
   input  logic [31:0] mem_ALUOut,
   input  logic [31:0] mem_lui,
   input  logic [31:0] dmemload,
   input  logic        mem_halt,
   output logic        wb_valid,
   output logic        regWr,
   output logic [2:0]  regSel,
   output logic [4:0]  regDst,
   output logic [31:0] nPC,
   output logic [31:0] ALUOut,
   output logic [31:0] lui,
   output logic [31:0] wb_dmemload,
   output logic        halt,
   output logic        mem_stall,
   output logic        dreq_mask,
   output logic [31:0] retired
);

   localparam int unsigned WORD_W = 32;
   localparam int unsigned REG_W  = 5;
   localparam int unsigned SEL_W  = 3;

   // RUN: no pending load; DWAIT: waiting for dhit; DHELD: load data parked until ihit
   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DWAIT = 2'd1,
      DHELD = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_next_state;
   logic [WORD_W-1:0]   r_held;
   logic [WORD_W-1:0]   w_next_held;
   logic                w_acc;
   logic                w_adv;
   logic                w_commit;

   assign w_acc     = mem_valid & (mem_dREN | mem_dWEN);
   assign w_adv     = ihit & (~w_acc | dhit | (r_state == DHELD));
   assign w_commit  = w_adv & ~flush;
   assign mem_stall = w_acc & ~w_adv;
   assign dreq_mask = (r_state == DHELD);

   // State and held-load register
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_state <= RUN;
         r_held  <= '0;
      end else begin
         r_state <= w_next_state;
         r_held  <= w_next_held;
      end
   end

   // Next-state logic; a flush accepted by the pipeline discards any pending load
   always_comb begin
      w_next_state = r_state;
      w_next_held  = r_held;
      case (r_state)
         RUN: begin
            if (w_acc && !dhit) begin
               w_next_state = DWAIT;
            end else if (w_acc && dhit && !ihit) begin
               w_next_state = DHELD;
               w_next_held  = dmemload;
            end
         end
         DWAIT: begin
            if (dhit && ihit) begin
               w_next_state = RUN;
            end else if (dhit && !ihit) begin
               w_next_state = DHELD;
               w_next_held  = dmemload;
            end
         end
         DHELD: begin
            if (ihit) w_next_state = RUN;
         end
         default: w_next_state = RUN;
      endcase
      if (flush && ihit) begin
         w_next_state = RUN;
         w_next_held  = '0;
      end
   end

   // Pipeline latch: capture on a committed advance, bubble otherwise, hold without ihit
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         wb_valid    <= 1'b0;
         regWr       <= 1'b0;
         regSel      <= '0;
         regDst      <= '0;
         nPC         <= '0;
         ALUOut      <= '0;
         lui         <= '0;
         wb_dmemload <= '0;
      end else if (ihit) begin
         if (w_commit) begin
            wb_valid    <= mem_valid;
            regWr       <= mem_regWr;
            regSel      <= mem_regSel;
            regDst      <= mem_regDst;
            nPC         <= mem_nPC;
            ALUOut      <= mem_ALUOut;
            lui         <= mem_lui;
            wb_dmemload <= (r_state == DHELD) ? r_held : dmemload;
         end else begin
            wb_valid    <= 1'b0;
            regWr       <= 1'b0;
            regSel      <= SEL_W'(0);
            regDst      <= REG_W'(0);
            nPC         <= WORD_W'(0);
            ALUOut      <= WORD_W'(0);
            lui         <= WORD_W'(0);
            wb_dmemload <= WORD_W'(0);
         end
      end
   end

   // Sticky halt and retired-instruction counter
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         halt    <= 1'b0;
         retired <= '0;
      end else if (w_commit && mem_valid) begin
         retired <= retired + WORD_W'(1);
         if (mem_halt) halt <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mem_wb_latch.sv
// Directed and randomized bench for mem_wb_latch against a behavioural model.
module tb_mem_wb_latch;

   logic        CLK;
   logic        nRST;
   logic        ihit, dhit, flush, mem_valid, mem_dREN, mem_dWEN, mem_regWr, mem_halt;
   logic [2:0]  mem_regSel;
   logic [4:0]  mem_regDst;
   logic [31:0] mem_nPC, mem_ALUOut, mem_lui, dmemload;
   logic        wb_valid, regWr, halt, mem_stall, dreq_mask;
   logic [2:0]  regSel;
   logic [4:0]  regDst;
   logic [31:0] nPC, ALUOut, lui, wb_dmemload, retired;

   int checks   = 0;
   int failures = 0;

   // model: expected outputs and pending-load bookkeeping
   logic        e_wb_valid, e_regWr, e_halt;
   logic [2:0]  e_regSel;
   logic [4:0]  e_regDst;
   logic [31:0] e_nPC, e_ALUOut, e_lui, e_dmem, e_retired;
   bit          m_wait, m_hold;
   logic [31:0] m_hold_data;

   mem_wb_latch dut (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .flush(flush),
      .mem_valid(mem_valid), .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN),
      .mem_regWr(mem_regWr), .mem_regSel(mem_regSel), .mem_regDst(mem_regDst),
      .mem_nPC(mem_nPC), .mem_ALUOut(mem_ALUOut), .mem_lui(mem_lui),
      .dmemload(dmemload), .mem_halt(mem_halt),
      .wb_valid(wb_valid), .regWr(regWr), .regSel(regSel), .regDst(regDst),
      .nPC(nPC), .ALUOut(ALUOut), .lui(lui), .wb_dmemload(wb_dmemload),
      .halt(halt), .mem_stall(mem_stall), .dreq_mask(dreq_mask), .retired(retired)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      {e_wb_valid, e_regWr, e_halt} = '0;
      e_regSel = '0; e_regDst = '0;
      e_nPC = '0; e_ALUOut = '0; e_lui = '0; e_dmem = '0; e_retired = '0;
      m_wait = 0; m_hold = 0; m_hold_data = '0;
   endtask

   task automatic check_regs(input string p);
      chk({p, ".wb_valid"},    32'(wb_valid),    32'(e_wb_valid));
      chk({p, ".regWr"},       32'(regWr),       32'(e_regWr));
      chk({p, ".regSel"},      32'(regSel),      32'(e_regSel));
      chk({p, ".regDst"},      32'(regDst),      32'(e_regDst));
      chk({p, ".nPC"},         nPC,              e_nPC);
      chk({p, ".ALUOut"},      ALUOut,           e_ALUOut);
      chk({p, ".lui"},         lui,              e_lui);
      chk({p, ".wb_dmemload"}, wb_dmemload,      e_dmem);
      chk({p, ".halt"},        32'(halt),        32'(e_halt));
      chk({p, ".retired"},     retired,          e_retired);
   endtask

   task automatic idle();
      {ihit, dhit, flush, mem_valid, mem_dREN, mem_dWEN, mem_regWr, mem_halt} = '0;
      mem_regSel = '0; mem_regDst = '0;
      mem_nPC = '0; mem_ALUOut = '0; mem_lui = '0; dmemload = '0;
   endtask

   task automatic rand_data();
      mem_regWr  = 1'($urandom);
      mem_regSel = 3'($urandom);
      mem_regDst = 5'($urandom);
      mem_nPC    = $urandom;
      mem_ALUOut = $urandom;
      mem_lui    = $urandom;
      dmemload   = $urandom;
   endtask

   // One clock: starts at a negedge with inputs applied, ends at the next negedge
   task automatic cycle(input string p);
      bit acc, adv, commit;
      acc    = mem_valid & (mem_dREN | mem_dWEN);
      adv    = ihit & (!acc | dhit | m_hold);
      commit = adv & !flush;
      #1;
      chk({p, ".mem_stall"}, 32'(mem_stall), 32'(acc & !adv));
      chk({p, ".dreq_mask"}, 32'(dreq_mask), 32'(m_hold));
      if (ihit) begin
         if (commit) begin
            e_wb_valid = mem_valid; e_regWr = mem_regWr; e_regSel = mem_regSel;
            e_regDst = mem_regDst; e_nPC = mem_nPC; e_ALUOut = mem_ALUOut; e_lui = mem_lui;
            e_dmem = m_hold ? m_hold_data : dmemload;
            if (mem_valid) begin
               e_retired = e_retired + 32'd1;
               if (mem_halt) e_halt = 1'b1;
            end
         end else begin
            e_wb_valid = 0; e_regWr = 0; e_regSel = '0; e_regDst = '0;
            e_nPC = '0; e_ALUOut = '0; e_lui = '0; e_dmem = '0;
         end
      end
      if (ihit && flush) begin
         m_wait = 0; m_hold = 0; m_hold_data = '0;
      end else if (m_hold) begin
         if (ihit) m_hold = 0;
      end else if (m_wait) begin
         if (dhit) begin
            m_wait = 0;
            if (!ihit) begin m_hold = 1; m_hold_data = dmemload; end
         end
      end else if (acc) begin
         if (!dhit) m_wait = 1;
         else if (!ihit) begin m_hold = 1; m_hold_data = dmemload; end
      end
      @(posedge CLK);
      #1;
      check_regs(p);
      @(negedge CLK);
   endtask

   initial begin
      idle();
      nRST = 1'b0;
      model_reset();
      repeat (2) @(negedge CLK);
      check_regs("rst");
      chk("rst.dreq_mask", 32'(dreq_mask), 32'd0);
      chk("rst.mem_stall", 32'(mem_stall), 32'd0);
      nRST = 1'b1;
      @(negedge CLK);

      // ALU op, no memory access
      mem_valid = 1; mem_regWr = 1; mem_regDst = 5'd5; mem_ALUOut = 32'h1234; ihit = 1;
      cycle("alu");
      chk("alu.retired_const", retired, 32'd1);
      chk("alu.regDst_const", 32'(regDst), 32'd5);

      // Load with dhit after three waiting cycles, ihit held high
      idle(); mem_valid = 1; mem_dREN = 1; mem_regWr = 1; mem_regSel = 3'd1;
      mem_regDst = 5'd9; ihit = 1;
      for (int i = 0; i < 3; i++) begin
         cycle("ld3.wait");
         chk("ld3.bubble", 32'(wb_valid), 32'd0);
      end
      dhit = 1; dmemload = 32'hCAFEF00D;
      cycle("ld3.hit");
      chk("ld3.data_const", wb_dmemload, 32'hCAFEF00D);
      idle(); ihit = 1;
      cycle("ld3.after");

      // Load completes while ihit low: data must be parked and replayed
      idle(); mem_valid = 1; mem_dREN = 1; mem_regWr = 1; mem_regDst = 5'd3;
      dhit = 1; dmemload = 32'h0BADC0DE;
      cycle("held.hit");
      dhit = 0; dmemload = 32'hDEADBEEF;
      cycle("held.w1");
      chk("held.mask_const", 32'(dreq_mask), 32'd1);
      cycle("held.w2");
      ihit = 1;
      cycle("held.adv");
      chk("held.data_const", wb_dmemload, 32'h0BADC0DE);

      // Flush while holding a parked load
      idle(); mem_valid = 1; mem_dREN = 1; mem_regWr = 1; dhit = 1; dmemload = 32'h1111_2222;
      cycle("fl.hit");
      dhit = 0; ihit = 1; flush = 1;
      cycle("fl.flush");
      chk("fl.retired_const", retired, 32'd3);
      idle(); ihit = 1;
      cycle("fl.after");

      // Flush without ihit while waiting is ignored
      idle(); mem_valid = 1; mem_dREN = 1; ihit = 1; mem_regWr = 1; mem_regDst = 5'd7;
      cycle("fn.enter");
      ihit = 0; flush = 1;
      cycle("fn.noihit");
      flush = 0; ihit = 1; dhit = 1; dmemload = 32'h5A5A_A5A5;
      cycle("fn.adv");

      // Store advances like a load
      idle(); mem_valid = 1; mem_dWEN = 1; ihit = 1; dhit = 1; dmemload = 32'h7777_0001;
      mem_ALUOut = 32'h100;
      cycle("st.adv");

      // Randomized traffic
      for (int i = 0; i < 300; i++) begin
         rand_data();
         ihit      = ($urandom_range(0, 3) != 0);
         dhit      = ($urandom_range(0, 2) == 0);
         flush     = ($urandom_range(0, 7) == 0);
         mem_valid = ($urandom_range(0, 4) != 0);
         mem_dREN  = ($urandom_range(0, 2) == 0);
         mem_dWEN  = ($urandom_range(0, 4) == 0);
         mem_halt  = 0;
         cycle("rnd");
      end
      idle(); ihit = 1; flush = 1;
      cycle("rnd.drain");

      // Halt is sticky across bubbles and flushes
      idle(); mem_valid = 1; mem_halt = 1; ihit = 1;
      cycle("halt.set");
      chk("halt.set_const", 32'(halt), 32'd1);
      idle(); ihit = 1;
      cycle("halt.bubble");
      flush = 1; mem_valid = 1;
      cycle("halt.flush");
      chk("halt.sticky_const", 32'(halt), 32'd1);

      // Retired counter wraps
      idle();
      force dut.retired = 32'hFFFF_FFFF;
      #1;
      release dut.retired;
      e_retired = 32'hFFFF_FFFF;
      @(negedge CLK);
      mem_valid = 1; ihit = 1;
      cycle("wrap");
      chk("wrap.zero_const", retired, 32'd0);

      // Asynchronous reset in the middle of a load wait
      idle(); mem_valid = 1; mem_dREN = 1; mem_regWr = 1; mem_regDst = 5'd4;
      mem_ALUOut = 32'hABCD; ihit = 1;
      cycle("rw.enter");
      #2;
      nRST = 1'b0;
      #1;
      model_reset();
      check_regs("rw.async");
      chk("rw.dreq_mask", 32'(dreq_mask), 32'd0);
      @(negedge CLK);
      nRST = 1'b1;
      dhit = 1; dmemload = 32'h600D_D00D;
      cycle("rw.post");
      chk("rw.post_data_const", wb_dmemload, 32'h600D_D00D);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      failures++;
      $display("FAIL timeout observed=running expected=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

endmodule
